// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes and operand widths for the calculator datapath
package calc_pkg;
  localparam int MANT_W = 34;
  localparam int EXP_W = 7;
  localparam logic [4:0] KEY_POINT = 5'd10;
  localparam logic [4:0] KEY_NEG = 5'd11;
  localparam logic [4:0] KEY_CLR = 5'd12;
  localparam logic [4:0] KEY_ENTER = 5'd13;
  localparam logic [34:0] M_MAX = 35'd17179869183;
endpackage

// File: rtl/mul10_add.sv
// mul10_add: y = x*10 + d using shift-add
module mul10_add
  import calc_pkg::*;
(
  input  logic [MANT_W-1:0] x,
  input  logic [3:0]        d,
  output logic [MANT_W-1:0] y
);
  assign y = (x << 3) + (x << 1) + {{(MANT_W-4){1'b0}}, d};
endmodule

// File: rtl/num_entry.sv
// num_entry: keypad key-event accumulator producing a decimal floating-point operand
module num_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    keyValid,
  input  logic [4:0]              keyCode,
  output logic                    busy,
  output logic                    done,
  output logic                    signRes,
  output logic [MANT_W-1:0]       mantRes,
  output logic signed [EXP_W-1:0] expRes,
  output logic [3:0]              digitCount,
  output logic                    pointSeen
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_MUL, S_COMMIT, S_DONE} state_t;
  state_t state_q;
  logic key_prev_q, done_q, ent_sign_q, point_seen_q, sign_res_q;
  logic [4:0] code_q;
  logic [3:0] digit_count_q;
  logic [MANT_W-1:0] ent_mant_q, mant_res_q, mul_y;
  logic signed [EXP_W-1:0] ent_exp_q, exp_res_q;
  logic digit_skip;
  mul10_add u_mul (.x(ent_mant_q), .d(code_q[3:0]), .y(mul_y));
  // leading zeros before the point carry no information and are not counted
  assign digit_skip = (digit_count_q == 4'(MAX_DIGITS)) ||
                      (ent_mant_q == '0 && code_q == 5'd0 && !point_seen_q);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_prev_q <= 1'b0;
      done_q <= 1'b0;
      code_q <= '0;
      ent_sign_q <= 1'b0;
      ent_mant_q <= '0;
      ent_exp_q <= '0;
      digit_count_q <= '0;
      point_seen_q <= 1'b0;
      sign_res_q <= 1'b0;
      mant_res_q <= '0;
      exp_res_q <= '0;
    end else begin
      key_prev_q <= keyValid;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (keyValid && !key_prev_q) begin
          code_q <= keyCode;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          state_q <= S_IDLE;
          if (code_q <= 5'd9) state_q <= S_MUL;
          else if (code_q == KEY_POINT) point_seen_q <= 1'b1;
          else if (code_q == KEY_NEG) ent_sign_q <= ~ent_sign_q;
          else if (code_q == KEY_ENTER) state_q <= S_COMMIT;
          else if (code_q == KEY_CLR) begin
            code_q <= '0;
            ent_sign_q <= 1'b0;
            ent_mant_q <= '0;
            ent_exp_q <= '0;
            digit_count_q <= '0;
            point_seen_q <= 1'b0;
          end
        end
        S_MUL: begin
          state_q <= S_IDLE;
          if (!digit_skip) begin
            ent_mant_q <= mul_y;
            digit_count_q <= digit_count_q + 4'd1;
            if (point_seen_q) ent_exp_q <= ent_exp_q - 7'sd1;
          end
        end
        S_COMMIT: begin
          // a zero operand is canonical: positive with zero exponent
          sign_res_q <= (ent_mant_q == '0) ? 1'b0 : ent_sign_q;
          exp_res_q <= (ent_mant_q == '0) ? '0 : ent_exp_q;
          mant_res_q <= ent_mant_q;
          code_q <= '0;
          ent_sign_q <= 1'b0;
          ent_mant_q <= '0;
          ent_exp_q <= '0;
          digit_count_q <= '0;
          point_seen_q <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign signRes = sign_res_q;
  assign mantRes = mant_res_q;
  assign expRes = exp_res_q;
  assign digitCount = digit_count_q;
  assign pointSeen = point_seen_q;
endmodule

// File: tb/tb_num_entry.sv
// tb_num_entry: directed key-sequence tests for num_entry
module tb_num_entry;
  logic clock = 1'b0, reset = 1'b1, keyValid = 1'b0;
  logic [4:0] keyCode = '0;
  logic busy, done, signRes, pointSeen;
  logic [33:0] mantRes;
  logic signed [6:0] expRes;
  logic [3:0] digitCount;
  int checks = 0, errors = 0, done_total = 0, done_base;

  num_entry dut (.clock(clock), .reset(reset), .keyValid(keyValid), .keyCode(keyCode),
    .busy(busy), .done(done), .signRes(signRes), .mantRes(mantRes), .expRes(expRes),
    .digitCount(digitCount), .pointSeen(pointSeen));

  always #5 clock = ~clock;
  always @(negedge clock) if (done === 1'b1) done_total++;

  task press(input logic [4:0] c);
    @(negedge clock); keyCode = c; keyValid = 1'b1;
    @(negedge clock); keyValid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task check_result(input string name, input logic s, input logic [33:0] m, input logic signed [6:0] e);
    checks++;
    if (done_total - done_base !== 1) begin errors++; $display("FAIL %s done pulses %0d expected 1", name, done_total - done_base); end
    checks++;
    if (signRes !== s) begin errors++; $display("FAIL %s sign %b expected %b", name, signRes, s); end
    checks++;
    if (mantRes !== m) begin errors++; $display("FAIL %s mant %0d expected %0d", name, mantRes, m); end
    checks++;
    if (expRes !== e) begin errors++; $display("FAIL %s exp %0d expected %0d", name, expRes, e); end
    checks++;
    if (digitCount !== 4'd0 || pointSeen !== 1'b0) begin errors++; $display("FAIL %s post-commit count %0d point %b expected 0 0", name, digitCount, pointSeen); end
  endtask

  task enter_and_check(input string name, input logic s, input logic [33:0] m, input logic signed [6:0] e);
    done_base = done_total;
    press(5'd13);
    check_result(name, s, m, e);
  endtask

  task test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, signRes, mantRes, expRes, digitCount, pointSeen} !== '0) begin
      errors++; $display("FAIL reset busy %b done %b sign %b mant %0d exp %0d cnt %0d pt %b expected all 0",
        busy, done, signRes, mantRes, expRes, digitCount, pointSeen);
    end
    reset = 1'b0;
  endtask

  task test_basic;
    press(5'd1); press(5'd2); press(5'd3);
    checks++;
    if (digitCount !== 4'd3) begin errors++; $display("FAIL basic count %0d expected 3", digitCount); end
    enter_and_check("basic", 1'b0, 34'd123, 7'sd0);
  endtask

  task test_fraction;
    press(5'd0); press(5'd0); press(5'd4); press(5'd10); press(5'd0); press(5'd5);
    checks++;
    if (digitCount !== 4'd3 || pointSeen !== 1'b1) begin errors++; $display("FAIL fraction count %0d pt %b expected 3 1", digitCount, pointSeen); end
    enter_and_check("fraction", 1'b0, 34'd405, -7'sd2);
  endtask

  task test_saturate;
    for (int i = 0; i < 11; i++) press(5'd9);
    checks++;
    if (digitCount !== 4'd10) begin errors++; $display("FAIL saturate count %0d expected 10", digitCount); end
    enter_and_check("saturate", 1'b0, 34'd9999999999, 7'sd0);
  endtask

  task test_negate;
    press(5'd11); press(5'd7); press(5'd10); press(5'd10); press(5'd2);
    checks++;
    if (digitCount !== 4'd2) begin errors++; $display("FAIL negate count %0d expected 2", digitCount); end
    enter_and_check("negate", 1'b1, 34'd72, -7'sd1);
  endtask

  task test_zero_clear;
    press(5'd11);
    enter_and_check("neg_zero", 1'b0, 34'd0, 7'sd0);
    press(5'd8); press(5'd12);
    checks++;
    if (digitCount !== 4'd0) begin errors++; $display("FAIL clear count %0d expected 0", digitCount); end
    press(5'd20); press(5'd6);
    enter_and_check("clear", 1'b0, 34'd6, 7'sd0);
  endtask

  task test_timing;
    @(negedge clock); keyCode = 5'd4; keyValid = 1'b1;
    @(negedge clock); keyValid = 1'b0;
    checks++;
    if (busy !== 1'b1 || digitCount !== 4'd0) begin errors++; $display("FAIL timing k busy %b cnt %0d expected 1 0", busy, digitCount); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || digitCount !== 4'd0) begin errors++; $display("FAIL timing k1 busy %b cnt %0d expected 1 0", busy, digitCount); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || digitCount !== 4'd1) begin errors++; $display("FAIL timing k2 busy %b cnt %0d expected 0 1", busy, digitCount); end
    enter_and_check("timing", 1'b0, 34'd4, 7'sd0);
  endtask

  task test_held;
    @(negedge clock); keyCode = 5'd3; keyValid = 1'b1;
    repeat (6) @(negedge clock);
    keyValid = 1'b0;
    repeat (3) @(negedge clock);
    enter_and_check("held", 1'b0, 34'd3, 7'sd0);
  endtask

  task test_busy_drop;
    @(negedge clock); keyCode = 5'd5; keyValid = 1'b1;
    @(negedge clock); keyValid = 1'b0;
    @(negedge clock); keyCode = 5'd7; keyValid = 1'b1;
    @(negedge clock); keyValid = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (digitCount !== 4'd1) begin errors++; $display("FAIL busy_drop count %0d expected 1", digitCount); end
    enter_and_check("busy_drop", 1'b0, 34'd5, 7'sd0);
  endtask

  task test_reset_mid;
    press(5'd2);
    done_base = done_total;
    @(negedge clock); keyCode = 5'd9; keyValid = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, signRes, mantRes, expRes, digitCount, pointSeen} !== '0) begin
      errors++; $display("FAIL reset_mid busy %b done %b sign %b mant %0d exp %0d cnt %0d pt %b expected all 0",
        busy, done, signRes, mantRes, expRes, digitCount, pointSeen);
    end
    @(negedge clock); reset = 1'b0;
    repeat (4) @(negedge clock);
    keyValid = 1'b0;
    checks++;
    if (done_total !== done_base || digitCount !== 4'd1) begin
      errors++; $display("FAIL reset_mid done pulses %0d cnt %0d expected 0 1", done_total - done_base, digitCount);
    end
    repeat (2) @(negedge clock);
    enter_and_check("reset_mid", 1'b0, 34'd9, 7'sd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fraction();
    test_saturate();
    test_negate();
    test_zero_clear();
    test_timing();
    test_held();
    test_busy_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/num_entry.md
# num_entry

Keypad number-entry accumulator for the calculator datapath. It turns a stream of key events into a decimal floating-point operand: sign, 34-bit unsigned mantissa, and signed 7-bit base-10 exponent. This is the same format the adder and other arithmetic stages consume. It sits between the keypad decoder and the operand registers, and signals each finished operand with a one-cycle `done` pulse.

## Interface
- `MAX_DIGITS`, default 10: maximum significant digits accepted. Must be ≤10 so the mantissa stays ≤ 9,999,999,999, below the 34-bit maximum of 17179869183.

- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, asynchronous, active-high.
- `keyValid` in 1: level strobe; one action per rising edge.
- `keyCode` in 5: key code, sampled on the `keyValid` rising edge.
  - 0–9: digit.
  - 10: decimal point.
  - 11: negate.
  - 12: clear.
  - 13: enter.
  - 14–31: ignored.
- `busy` out 1: high whenever state ≠ S_IDLE.
- `done` out 1: one-cycle pulse when the result outputs are valid.
- `signRes` out 1: committed sign (1 = negative).
- `mantRes` out 34: committed mantissa.
- `expRes` out 7 signed: committed exponent; value = mant × 10^exp.
- `digitCount` out 4: live count of significant digits entered.
- `pointSeen` out 1: live flag, decimal point already entered.

## Operation
- Key detection: `keyPrev` register; event = `keyValid && !keyPrev`. `keyPrev` updates every cycle in every state.
- Events arriving while `busy` is high are dropped, not queued.
- States:
  - **S_IDLE**: on an event, latch `keyCode` into `code`, go to S_DECODE.
  - **S_DECODE**:
    - digit → S_MUL.
    - point: set `pointSeen` (no-op if already set) → S_IDLE.
    - negate: toggle `entSign` → S_IDLE.
    - clear: zero all entry registers → S_IDLE.
    - enter → S_COMMIT.
    - code ≥14 → S_IDLE, no change.
  - **S_MUL**: apply the digit rules below → S_IDLE.
  - **S_COMMIT**: copy entry registers to the result outputs, then zero the entry registers → S_DONE.
  - **S_DONE**: `done` <= 1 → S_IDLE.
- Digit rules, evaluated in order:
  1. If `digitCount == MAX_DIGITS`: ignore.
  2. Else if `entMant == 0`, digit 0, and `!pointSeen`: ignore (leading zero, not counted).
  3. Else:
     - `entMant` <= `entMant*10 + digit`, computed as `(x<<3)+(x<<1)+d`.
     - `digitCount`++.
     - If `pointSeen`, `entExp`--.
- Fractional zeros (e.g. "0.05") count as digits and decrement the exponent.
- Exponent range produced: −10..0. No clamping is needed.
- Commit of a zero mantissa always yields `signRes`=0, `expRes`=0, regardless of negate presses.
- Entry registers:
  - `entSign`, `entMant`, `entExp`, `digitCount`, `pointSeen`, `code`.
  - Zeroed by clear, by commit, and by reset.
- `done` defaults to 0 in every cycle not in S_DONE.

## Timing
- Reset values:
  - state S_IDLE.
  - `busy`=0, `done`=0.
  - `signRes`=0, `mantRes`=0, `expRes`=0.
  - `digitCount`=0, `pointSeen`=0.
  - All entry registers and `keyPrev` = 0.
- An event detected at edge k:
  - `busy` is high after k.
  - Digit: mantissa, exponent and count updated at edge k+2; `busy` low after k+2.
  - Point, negate, clear: applied at edge k+1.
  - Enter: result outputs updated at k+2; `done` high for exactly the cycle after edge k+3; `busy` low after k+3.
- Result outputs hold their value until the next commit or reset.
- Minimum event spacing for guaranteed acceptance:
  - 3 cycles for digits.
  - 4 cycles for enter.
  - 2 cycles for all other keys.
- `keyValid` held high indefinitely gives exactly one action.
- Reset mid-operation (any state): immediate return to reset values.
  - No `done` pulse.
  - Partially entered number discarded.
  - A `keyValid` that is still high after reset releases counts as a new edge, because `keyPrev` was cleared.

## Structure
- Shared package `calc_pkg` holds:
  - Key-code localparams: `KEY_POINT`=10, `KEY_NEG`=11, `KEY_CLR`=12, `KEY_ENTER`=13.
  - `M_MAX` = 35'd17179869183.
  - Operand widths: mantissa 34, exponent 7.
- The FSM state enum stays local to this module.
- One sub-module, `mul10_add`: combinational `y = (x<<3)+(x<<1)+d`.
  - 34-bit `x`, 4-bit `d`, 34-bit `y`.
  - Reusable by other stages.

## Test plan
- Keys 1,2,3,enter → one `done` pulse; `signRes`=0, `mantRes`=123, `expRes`=0; `digitCount` back to 0 after commit.
- Keys 0,0,4,point,0,5,enter → `mantRes`=405, `expRes`=−2; `digitCount` before enter = 3.
- Eleven presses of 9 then enter → `mantRes`=9999999999, `expRes`=0; 11th digit ignored; `digitCount` saturates at 10.
- Keys negate,7,point,point,2,enter → `signRes`=1, `mantRes`=72, `expRes`=−1; second point is a no-op.
- Negate, enter → `signRes`=0, `mantRes`=0, `expRes`=0. Also keys 8,clear,6,enter → `mantRes`=6.
- Edge cases:
  - `keyValid` held high 6 cycles with code 3, then enter → `mantRes`=3.
  - An event pulse during `busy` → dropped.
  - Reset asserted while in S_MUL → all outputs zero, no `done`.
